seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand/result width in bits (legal range 4..64).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  operand/opcode presented.
REQ-005 SHALL have port in_ready  output  1  block can accept an operation.
REQ-006 SHALL have ports a and b  input  WIDTH each  operands.
REQ-007 SHALL have port op_code  input  4  operation select.
REQ-008 SHALL have port out_valid  output  1  result and flags valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port result  output  WIDTH  operation result.
REQ-011 SHALL have ports flag_z, flag_n, flag_c, flag_v, flag_err  output  1 each  zero, negative, carry/borrow, signed overflow, illegal opcode.

Function
REQ-012 SHALL implement an FSM with states IDLE, BUSY and DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-013 SHALL accept an operation when in_valid & in_ready and capture a, b and op_code internally; later input changes SHALL NOT affect that operation.
REQ-014 SHALL decode opcodes: 0000 ADD, 0001 SUB (a-b), 0010 AND, 0011 OR, 0100 XOR, 0101 NOT (~a), 0110 SHL (a<<b), 0111 SHR logical (a>>b), 1000 SRA arithmetic, 1001 MUL (low WIDTH bits of a*b, unsigned), 1010 SLT (result 1 if signed a<b, else 0).
REQ-015 For every opcode except MUL: IDLE->DONE on acceptance, with result and flags registered at that edge (latency 1 cycle).
REQ-016 For MUL: IDLE->BUSY on acceptance; one shift-and-add iteration per cycle for exactly WIDTH cycles; then ->DONE (latency WIDTH+1 cycles).
REQ-017 DONE SHALL hold result and flags stable until out_ready=1, then go to IDLE on that edge; in_ready stays 0 in that cycle.
REQ-018 Shift amount SHALL be the full unsigned value of b; if b>=WIDTH, SHL/SHR give 0 and SRA gives WIDTH copies of a[WIDTH-1].
REQ-019 flag_z=1 iff result==0; flag_n=result[WIDTH-1] for all opcodes.
REQ-020 flag_c: ADD carry-out; SUB 1 iff unsigned a<b (borrow); MUL 1 iff the upper WIDTH bits of the full 2*WIDTH product are nonzero; 0 otherwise.
REQ-021 flag_v: ADD/SUB two's-complement signed overflow; 0 for all other opcodes.
REQ-022 An opcode 1011-1111 SHALL be accepted with 1-cycle latency, result=0, flag_err=1, flag_z=1, other flags 0; flag_err=0 for legal opcodes.
REQ-023 in_valid while not IDLE SHALL be ignored; no operation is queued or lost silently (in_ready=0 signals back-pressure).

Reset
REQ-024 While rst_n=0, the block SHALL be in IDLE with result=0, all flags=0, out_valid=0 and in_ready=1 (after release), asynchronously on assertion.
REQ-025 Reset asserted in BUSY or DONE SHALL abort the operation with no output produced; the first edge after release behaves as IDLE.

Verification
REQ-026 WIDTH=32, ADD a=0x0000000A b=0x00000005, out_ready=1 -> one cycle later out_valid=1, result=0x0000000F, flags z/n/c/v/err=0.
REQ-027 SUB a=0x80000000 b=0x00000001 -> result=0x7FFFFFFF, flag_v=1, flag_c=0; SUB a=1 b=2 -> result=0xFFFFFFFF, flag_c=1, flag_n=1.
REQ-028 MUL a=0x00010000 b=0x00010000 -> out_valid exactly 33 cycles after acceptance, result=0, flag_z=1, flag_c=1; in_valid pulses during BUSY ignored.
REQ-029 SRA a=0x80000000 b=40 -> 0xFFFFFFFF; SHL a=1 b=31 -> 0x80000000; SHR a=0xFFFFFFFF b=32 -> 0.
REQ-030 Hold out_ready=0 for 5 cycles after out_valid -> result/flags stable, in_ready=0; then out_ready=1 -> IDLE next cycle; opcode 1111 -> flag_err=1, result=0.
REQ-031 Assert rst_n=0 mid-MUL (cycle 10 of BUSY) -> outputs cleared immediately, out_valid never asserted for that op; next ADD after release completes normally.

Source files
------------

// File: rtl/seq_alu.sv
// Sequential ALU with a valid/ready handshake on both sides. Every opcode
// except MUL completes one cycle after acceptance; MUL runs a WIDTH-cycle shift-and-add.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_err
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
        OP_XOR = 4'd4, OP_NOT = 4'd5, OP_SHL = 4'd6, OP_SHR = 4'd7,
        OP_SRA = 4'd8, OP_MUL = 4'd9, OP_SLT = 4'd10
    } op_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               flag_z_q, flag_z_d;
    logic               flag_n_q, flag_n_d;
    logic               flag_c_q, flag_c_d;
    logic               flag_v_q, flag_v_d;
    logic               flag_err_q, flag_err_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      count_q, count_d;

    logic [WIDTH:0]     sum_ext, diff_ext;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_v, alu_err;

    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};
    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Single-cycle operations, evaluated on the live inputs and captured at the accepting edge.
    always_comb begin
        // NOTE: every output gets a default first so no path can leave it unassigned and infer a latch.
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        case (op_code)
            OP_ADD: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff_ext[WIDTH-1:0];
                alu_c   = diff_ext[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_NOT: alu_res = ~a;
            // Shifts use the full value of b, so amounts >= WIDTH flush to zero or sign.
            OP_SHL: alu_res = a << b;
            OP_SHR: alu_res = a >> b;
            OP_SRA: alu_res = $signed(a) >>> b;
            OP_MUL: alu_res = '0;
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            default: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        flag_z_d   = flag_z_q;
        flag_n_d   = flag_n_q;
        flag_c_d   = flag_c_q;
        flag_v_d   = flag_v_q;
        flag_err_d = flag_err_q;
        mcand_d    = mcand_q;
        acc_d      = acc_q;
        mplier_d   = mplier_q;
        count_d    = count_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (op_code == OP_MUL) begin
                        state_d  = BUSY;
                        mcand_d  = {{WIDTH{1'b0}}, a};
                        mplier_d = b;
                        acc_d    = '0;
                        count_d  = '0;
                    end else begin
                        state_d    = DONE;
                        result_d   = alu_res;
                        flag_z_d   = (alu_res == '0);
                        flag_n_d   = alu_res[WIDTH-1];
                        flag_c_d   = alu_c;
                        flag_v_d   = alu_v;
                        flag_err_d = alu_err;
                    end
                end
            end
            BUSY: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d    = DONE;
                    result_d   = acc_next[WIDTH-1:0];
                    flag_z_d   = (acc_next[WIDTH-1:0] == '0);
                    flag_n_d   = acc_next[WIDTH-1];
                    flag_c_d   = |acc_next[2*WIDTH-1:WIDTH];
                    flag_v_d   = 1'b0;
                    flag_err_d = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the multiplier datapath registers are reset too, so an aborted MUL leaves no residue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            result_q   <= '0;
            flag_z_q   <= 1'b0;
            flag_n_q   <= 1'b0;
            flag_c_q   <= 1'b0;
            flag_v_q   <= 1'b0;
            flag_err_q <= 1'b0;
            mcand_q    <= '0;
            acc_q      <= '0;
            mplier_q   <= '0;
            count_q    <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge value of the others.
            state_q    <= state_d;
            result_q   <= result_d;
            flag_z_q   <= flag_z_d;
            flag_n_q   <= flag_n_d;
            flag_c_q   <= flag_c_d;
            flag_v_q   <= flag_v_d;
            flag_err_q <= flag_err_d;
            mcand_q    <= mcand_d;
            acc_q      <= acc_d;
            mplier_q   <= mplier_d;
            count_q    <= count_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign flag_z    = flag_z_q;
    assign flag_n    = flag_n_q;
    assign flag_c    = flag_c_q;
    assign flag_v    = flag_v_q;
    assign flag_err  = flag_err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=32): hand-computed vectors, handshake timing,
// MUL latency, back-pressure hold and reset abort.
module tb_seq_alu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op_code;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        flag_z, flag_n, flag_c, flag_v, flag_err;
    logic [4:0]  flags;

    int vectors = 0;
    int errors  = 0;

    assign flags = {flag_z, flag_n, flag_c, flag_v, flag_err};

    seq_alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op_code   (op_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .flag_err  (flag_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle and out_ready=1; returns at a negedge, idle again.
    // Flags are packed {z,n,c,v,err}.
    task automatic alu_op(input string tag, input logic [3:0] op, input logic [31:0] ia,
                          input logic [31:0] ib, input logic [31:0] er, input logic [4:0] ef);
        in_valid = 1'b1;
        op_code  = op;
        a        = ia;
        b        = ib;
        @(negedge clk);
        in_valid = 1'b0;
        a        = ~ia;
        b        = ~ib;
        check({tag, " out_valid"}, out_valid, 1'b1);
        check({tag, " result"}, result, er);
        check({tag, " flags"}, flags, ef);
        @(negedge clk);
        check({tag, " back to idle"}, {in_ready, out_valid}, 2'b10);
    endtask

    initial begin
        int n;
        int seen;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        op_code   = '0;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("reset result", result, 32'h0);
        check("reset flags", flags, 5'b00000);
        check("reset out_valid", out_valid, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("post-reset in_ready", in_ready, 1'b1);

        // Single-cycle operations
        alu_op("add basic",   4'h0, 32'h0000000A, 32'h00000005, 32'h0000000F, 5'b00000);
        alu_op("sub ovf",     4'h1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 5'b00010);
        alu_op("sub borrow",  4'h1, 32'h00000001, 32'h00000002, 32'hFFFFFFFF, 5'b01100);
        alu_op("add carry",   4'h0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b10100);
        alu_op("add ovf",     4'h0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'b01010);
        alu_op("and",         4'h2, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 5'b00000);
        alu_op("or",          4'h3, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 5'b00000);
        alu_op("xor",         4'h4, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 5'b00000);
        alu_op("not",         4'h5, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 5'b01000);
        alu_op("shl 31",      4'h6, 32'h00000001, 32'd31,       32'h80000000, 5'b01000);
        alu_op("shl huge",    4'h6, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 5'b10000);
        alu_op("shr 4",       4'h7, 32'h80000000, 32'd4,        32'h08000000, 5'b00000);
        alu_op("shr 32",      4'h7, 32'hFFFFFFFF, 32'd32,       32'h00000000, 5'b10000);
        alu_op("sra 4",       4'h8, 32'h80000000, 32'd4,        32'hF8000000, 5'b01000);
        alu_op("sra 40",      4'h8, 32'h80000000, 32'd40,       32'hFFFFFFFF, 5'b01000);
        alu_op("sra pos 40",  4'h8, 32'h7FFFFFFF, 32'd40,       32'h00000000, 5'b10000);
        alu_op("slt true",    4'hA, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 5'b00000);
        alu_op("slt false",   4'hA, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 5'b10000);
        alu_op("illegal 1011", 4'hB, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 5'b10001);
        alu_op("illegal 1111", 4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 5'b10001);

        // MUL latency with in_valid pulses during BUSY
        in_valid = 1'b1;
        op_code  = 4'h9;
        a        = 32'h00010000;
        b        = 32'h00010000;
        @(negedge clk);
        in_valid = 1'b0;
        a        = 32'h0;
        b        = 32'h0;
        n        = 1;
        check("mul busy in_ready", {in_ready, out_valid}, 2'b00);
        while (!out_valid && n < 100) begin
            if (n == 5 || n == 20) begin
                in_valid = 1'b1;
                op_code  = 4'h0;
                a        = 32'h1;
                b        = 32'h1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        check("mul latency", n, 33);
        check("mul result", result, 32'h0);
        check("mul flags", flags, 5'b10100);
        @(negedge clk);
        check("mul back to idle", {in_ready, out_valid}, 2'b10);
        @(negedge clk);
        check("mul nothing queued", out_valid, 1'b0);

        // Full-width MUL: 0xFFFFFFFF^2 = 0xFFFFFFFE_00000001
        n = 0;
        in_valid = 1'b1;
        op_code  = 4'h9;
        a        = 32'hFFFFFFFF;
        b        = 32'hFFFFFFFF;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("mul2 result", result, 32'h00000001);
        check("mul2 flags", flags, 5'b00100);
        @(negedge clk);

        // Back-pressure: hold out_ready low for 5 cycles
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op_code   = 4'h0;
        a         = 32'd3;
        b         = 32'd4;
        @(negedge clk);
        check("hold first", {out_valid, result}, {1'b1, 32'h7});
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a        = 32'd100;
            b        = 32'd100;
            @(negedge clk);
            check("hold result", result, 32'h7);
            check("hold flags", flags, 5'b00000);
            check("hold handshake", {in_ready, out_valid}, 2'b01);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("hold release idle", {in_ready, out_valid}, 2'b10);
        @(negedge clk);
        check("hold nothing queued", out_valid, 1'b0);

        // Reset in the middle of a MUL
        in_valid = 1'b1;
        op_code  = 4'h9;
        a        = 32'd5;
        b        = 32'd7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort result", result, 32'h0);
        check("abort flags", flags, 5'b00000);
        check("abort handshake", {in_ready, out_valid}, 2'b10);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort no output", seen, 0);
        alu_op("add after abort", 4'h0, 32'h00000010, 32'h00000020, 32'h00000030, 5'b00000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
